// File: rtl/dcache_mem_ctrl_if.sv
// dcache_mem_ctrl_if: DCache miss port plus the shared byte-wide RAM bus.
interface dcache_mem_ctrl_if #(parameter int BLOCK_WIDTH = 4);
  localparam int AW = 32 - BLOCK_WIDTH;
  localparam int DW = (2 ** BLOCK_WIDTH) * 8;
  logic          miss;
  logic [AW-1:0] miss_addr;
  logic          read_write;
  logic [DW-1:0] write_back;
  logic          mem_data_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          accept_write;
  logic          bus_req;
  logic          bus_grant;
  logic [31:0]   ram_addr;
  logic          ram_write;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  modport master (
    output miss, miss_addr, read_write, write_back, bus_grant, ram_rdata,
    input  mem_data_valid, mem_addr, mem_data, accept_write, bus_req, ram_addr, ram_write, ram_wdata
  );
  modport slave (
    input  miss, miss_addr, read_write, write_back, bus_grant, ram_rdata,
    output mem_data_valid, mem_addr, mem_data, accept_write, bus_req, ram_addr, ram_write, ram_wdata
  );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: DCache miss service engine; byte-serial block writeback or fill over a
// req/grant-shared RAM bus.
module dcache_mem_ctrl #(parameter int BLOCK_WIDTH = 4) (
  input logic             clk,
  input logic             rst_n,
  dcache_mem_ctrl_if.slave bus
);
  localparam int BS = 2 ** BLOCK_WIDTH;
  localparam int AW = 32 - BLOCK_WIDTH;
  localparam int DW = BS * 8;
  localparam logic [BLOCK_WIDTH:0] LAST = (BLOCK_WIDTH + 1)'(BS - 1);
  localparam logic [BLOCK_WIDTH:0] FULL = (BLOCK_WIDTH + 1)'(BS);
  typedef enum logic [2:0] {IDLE, REQ, WRITE, READ, DONE} state_t;
  state_t               state;
  logic [BLOCK_WIDTH:0] cnt;
  logic [BLOCK_WIDTH:0] nxt;
  logic [AW-1:0]        addr;
  logic                 rw;
  logic [DW-1:0]        blk;
  assign nxt = cnt + 1'b1;
  // blk shifts right a byte per cycle: it feeds writeback bytes out and gathers fill bytes in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      addr               <= '0;
      rw                 <= 1'b0;
      blk                <= '0;
      bus.mem_data_valid <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_data       <= '0;
      bus.accept_write   <= 1'b0;
      bus.bus_req        <= 1'b0;
      bus.ram_addr       <= '0;
      bus.ram_write      <= 1'b0;
      bus.ram_wdata      <= '0;
    end else
      case (state)
        IDLE: if (bus.miss) begin
          addr        <= bus.miss_addr;
          rw          <= bus.read_write;
          blk         <= bus.write_back;
          bus.bus_req <= 1'b1;
          state       <= REQ;
        end
        REQ: if (bus.bus_grant) begin
          cnt           <= '0;
          bus.ram_addr  <= {addr, {BLOCK_WIDTH{1'b0}}};
          bus.ram_write <= !rw;
          bus.ram_wdata <= rw ? '0 : blk[7:0];
          blk           <= rw ? blk : blk >> 8;
          state         <= rw ? READ : WRITE;
        end
        WRITE: if (cnt == LAST) begin
          bus.ram_addr     <= '0;
          bus.ram_write    <= 1'b0;
          bus.ram_wdata    <= '0;
          bus.bus_req      <= 1'b0;
          bus.accept_write <= 1'b1;
          bus.mem_addr     <= addr;
          state            <= DONE;
        end else begin
          cnt           <= nxt;
          bus.ram_addr  <= {addr, nxt[BLOCK_WIDTH-1:0]};
          bus.ram_wdata <= blk[7:0];
          blk           <= blk >> 8;
        end
        READ: begin
          // read data trails its address by a cycle, so capture starts at cnt 1 and ends at BS
          if (|cnt) blk <= {bus.ram_rdata, blk[DW-1:8]};
          if (cnt == FULL) begin
            bus.bus_req        <= 1'b0;
            bus.mem_data_valid <= 1'b1;
            bus.mem_data       <= {bus.ram_rdata, blk[DW-1:8]};
            bus.mem_addr       <= addr;
            state              <= DONE;
          end else begin
            cnt          <= nxt;
            bus.ram_addr <= nxt == FULL ? '0 : {addr, nxt[BLOCK_WIDTH-1:0]};
          end
        end
        DONE: begin
          bus.mem_data_valid <= 1'b0;
          bus.accept_write   <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: directed cycle-by-cycle checks of fill, writeback, grant stall,
// back-to-back evict+load, mid-transfer input changes and async reset.
module tb_dcache_mem_ctrl;
  localparam int BW = 4;
  localparam int BS = 16;
  localparam int AW = 28;
  localparam int DW = 128;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  always #5 clk = ~clk;
  dcache_mem_ctrl_if #(.BLOCK_WIDTH(BW)) bus();
  dcache_mem_ctrl #(.BLOCK_WIDTH(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // RAM returns the low address byte one cycle after the address is driven
  always @(posedge clk) bus.ram_rdata <= bus.ram_addr[7:0];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_outs(input int k, input logic b, input logic [31:0] ra, input logic w,
                          input logic [7:0] wd, input logic v, input logic a);
    chk($sformatf("bus_req c%0d", k), DW'(bus.bus_req), DW'(b));
    chk($sformatf("ram_addr c%0d", k), DW'(bus.ram_addr), DW'(ra));
    chk($sformatf("ram_write c%0d", k), DW'(bus.ram_write), DW'(w));
    chk($sformatf("ram_wdata c%0d", k), DW'(bus.ram_wdata), DW'(wd));
    chk($sformatf("mem_data_valid c%0d", k), DW'(bus.mem_data_valid), DW'(v));
    chk($sformatf("accept_write c%0d", k), DW'(bus.accept_write), DW'(a));
    chk($sformatf("mem_addr c%0d", k), DW'(bus.mem_addr), DW'(last_addr));
    chk($sformatf("mem_data c%0d", k), bus.mem_data, last_data);
  endtask
  function automatic logic [DW-1:0] fill_data(input logic [AW-1:0] a);
    logic [31:0] base;
    logic [DW-1:0] d;
    base = {a, 4'h0};
    d = '0;
    for (int i = 0; i < BS; i++) d[8*i +: 8] = 8'(base + 32'(i));
    return d;
  endfunction
  // Called #1 after a posedge with the DUT idle; returns #1 into the following idle cycle
  task automatic run_txn(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] wb,
                         input int g, input bit mutate);
    int s;
    int d;
    s = 2 + g;
    d = rw ? s + BS + 1 : s + BS;
    chk_outs(0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    bus.miss = 1'b1;
    bus.miss_addr = a;
    bus.read_write = rw;
    bus.write_back = wb;
    bus.bus_grant = (g == 0);
    for (int k = 1; k <= d; k++) begin
      logic [31:0] ra;
      logic w;
      logic [7:0] wd;
      bit in_x;
      @(posedge clk); #1;
      bus.bus_grant = (k >= 1 + g);
      if (mutate && k == 5) begin
        bus.miss = 1'b0;
        bus.miss_addr = ~a;
        bus.write_back = ~wb;
        bus.read_write = ~rw;
      end
      in_x = k >= s && k < s + BS;
      ra = in_x ? {a, 4'(k - s)} : '0;
      w = in_x && !rw;
      wd = w ? 8'(wb >> (8 * (k - s))) : '0;
      if (k == d) begin
        last_addr = a;
        if (rw) last_data = fill_data(a);
      end
      chk_outs(k, k < d, ra, w, wd, k == d && rw, k == d && !rw);
    end
    bus.bus_grant = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    bus.miss = 1'b0;
    bus.miss_addr = '0;
    bus.read_write = 1'b0;
    bus.write_back = '0;
    bus.bus_grant = 1'b0;
    #2;
    chk_outs(-1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(28'h10, 1'b1, '0, 0, 0);
    chk("fill block", bus.mem_data, 128'h0f0e0d0c0b0a09080706050403020100);
    bus.miss = 1'b0;
    run_txn(28'h20, 1'b0, 128'h00112233445566778899aabbccddeeff, 0, 0);
    bus.miss = 1'b0;
    run_txn(28'h50, 1'b1, '0, 5, 0);
    run_txn(28'h30, 1'b0, 128'hdeadbeef_01234567_89abcdef_cafef00d, 0, 0);
    run_txn(28'h30, 1'b1, '0, 0, 0);
    bus.miss = 1'b0;
    run_txn(28'h60, 1'b0, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 0, 1);
    run_txn(28'h70, 1'b1, '0, 0, 1);
    bus.miss = 1'b1;
    bus.miss_addr = 28'h40;
    bus.read_write = 1'b1;
    bus.bus_grant = 1'b1;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    last_addr = '0;
    last_data = '0;
    chk_outs(8, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(28'h40, 1'b1, '0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
